alu_arbiter: RTL

Shares the single 64-bit ALU (AND/OR/ADD/SUB) between two requesters, for example the EX stage and the address/branch-compare unit. Each requester uses a valid/ready handshake. Round-robin arbitration picks one request per cycle. The block instantiates the ALU and registers its result and zero flag into one output stage that supports backpressure. The result carries the id of the requester that issued it.

---
 rtl/alu_arbiter_pkg.sv | 14 +
 rtl/alu_arbiter_alu.sv | 29 ++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the arbitrated ALU: op codes and requester ids.
package alu_arbiter_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: AND/OR/ADD/SUB, wrapping arithmetic, zero flag.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OP_WIDTH   = 4
) (
    input  logic [OP_WIDTH-1:0]   operation_i,
    input  logic [DATA_WIDTH-1:0] input_data1_i,
    input  logic [DATA_WIDTH-1:0] input_data2_i,
    output logic [DATA_WIDTH-1:0] result_c_o,
    output logic                  zero_c_o
);

    // Operation decode; unsupported codes yield zero.
    always_comb begin
        result_c_o = '0;
        case (operation_i)
            OP_WIDTH'(ALU_AND): result_c_o = input_data1_i & input_data2_i;
            OP_WIDTH'(ALU_OR):  result_c_o = input_data1_i | input_data2_i;
            OP_WIDTH'(ALU_ADD): result_c_o = input_data1_i + input_data2_i;
            OP_WIDTH'(ALU_SUB): result_c_o = input_data1_i - input_data2_i;
            default:            result_c_o = '0;
        endcase
    end

    assign zero_c_o = (result_c_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a single registered output stage that supports backpressure.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_operation,
    input  logic [DATA_WIDTH-1:0] req0_input_data1,
    input  logic [DATA_WIDTH-1:0] req0_input_data2,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_operation,
    input  logic [DATA_WIDTH-1:0] req1_input_data1,
    input  logic [DATA_WIDTH-1:0] req1_input_data2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_id,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero
);

    logic                  out_valid_q;
    logic                  out_id_q;
    logic [DATA_WIDTH-1:0] out_result_q;
    logic                  out_zero_q;
    logic                  last_grant_q;

    logic                  stage_free;
    logic                  grant_vld;
    logic                  grant_id;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;

    // The stage can take a new op when empty or being drained this cycle.
    assign stage_free = !out_valid_q || out_ready;

    // Round-robin grant: on contention favour the requester not served last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = REQ0;
        if (stage_free) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = !last_grant_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = REQ0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = REQ1;
            end
        end
    end

    assign req0_ready = grant_vld && (grant_id == REQ0);
    assign req1_ready = grant_vld && (grant_id == REQ1);

    // Steer the granted requester onto the ALU; idle inputs are all zero.
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (grant_vld) begin
            if (grant_id == REQ1) begin
                alu_op = req1_operation;
                alu_a  = req1_input_data1;
                alu_b  = req1_input_data2;
            end else begin
                alu_op = req0_operation;
                alu_a  = req0_input_data1;
                alu_b  = req0_input_data2;
            end
        end
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH)
    ) u_alu (
        .operation_i   (alu_op),
        .input_data1_i (alu_a),
        .input_data2_i (alu_b),
        .result_c_o    (alu_result),
        .zero_c_o      (alu_zero)
    );

    // Output stage: load on transfer (also covers drain+reload), clear on pure drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_id_q     <= REQ0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            last_grant_q <= REQ1;
        end else if (grant_vld) begin
            out_valid_q  <= 1'b1;
            out_id_q     <= grant_id;
            out_result_q <= alu_result;
            out_zero_q   <= alu_zero;
            last_grant_q <= grant_id;
        end else if (out_valid_q && out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;

endmodule
